// File: rtl/hex_seven_seg.sv
// hex_seven_seg: registered hexadecimal to seven-segment decoder.
// It holds one digit register and a valid flag, and drives a registered segment output.
// Segment bit order is {g,f,e,d,c,b,a}.
// The ACTIVE_LOW parameter sets the drive polarity. 1 means a segment is lit by driving 0.
// Optional feature: define HEX_SEVEN_SEG_LAMP_TEST_EN to add the lamp_test input.
// lamp_test lights every segment and does not change the stored digit.
module hex_seven_seg #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic       load,
  input  logic       blank,
`ifdef HEX_SEVEN_SEG_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic [6:0] seg0,
  output logic       valid
);

  // Drive codes for a dark display and a fully lit display at the chosen polarity.
  localparam logic [6:0] SEG_DARK = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_LIT  = ACTIVE_LOW ? 7'h00 : 7'h7F;

  logic [3:0] digit_reg;
  logic [3:0] digit_next;
  logic       valid_reg;
  logic       valid_next;
  logic [6:0] seg_reg;
  logic [6:0] seg_next;
  logic [6:0] pattern_low;   // decoded pattern, 0 = lit
  logic [6:0] pattern_drive; // decoded pattern at the chosen polarity

  // Next digit and valid flag. The decoder looks at the incoming digit,
  // so a digit loaded at an edge is shown right after that same edge.
  always_comb begin
    digit_next = digit_reg;
    valid_next = valid_reg;
    if (load) begin
      digit_next = a;
      valid_next = 1'b1;
    end
  end

  // Hex-to-segment lookup, written in active-low form ({g..a}, 0 = lit).
  always_comb begin
    pattern_low = 7'h7F;
    case (digit_next)
      4'h0: pattern_low = 7'b1000000;
      4'h1: pattern_low = 7'b1111001;
      4'h2: pattern_low = 7'b0100100;
      4'h3: pattern_low = 7'b0110000;
      4'h4: pattern_low = 7'b0011001;
      4'h5: pattern_low = 7'b0010010;
      4'h6: pattern_low = 7'b0000010;
      4'h7: pattern_low = 7'b1111000;
      4'h8: pattern_low = 7'b0000000;
      4'h9: pattern_low = 7'b0010000;
      4'hA: pattern_low = 7'b0001000;
      4'hB: pattern_low = 7'b0000011;
      4'hC: pattern_low = 7'b1000110;
      4'hD: pattern_low = 7'b0100001;
      4'hE: pattern_low = 7'b0000110;
      4'hF: pattern_low = 7'b0001110;
      default: pattern_low = 7'h7F;
    endcase
  end

  // Apply the output polarity to each segment.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_polarity
      assign pattern_drive[gi] = ACTIVE_LOW ? pattern_low[gi] : ~pattern_low[gi];
    end
  endgenerate

  // Output priority: lamp test, then blank, then dark until the first load, then the digit.
  always_comb begin
    seg_next = pattern_drive;
    if (!valid_next) begin
      seg_next = SEG_DARK;
    end
    if (blank) begin
      seg_next = SEG_DARK;
    end
`ifdef HEX_SEVEN_SEG_LAMP_TEST_EN
    if (lamp_test) begin
      seg_next = SEG_LIT;
    end
`endif
  end

  // State and output registers. Reset has the highest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_reg <= 4'h0;
      valid_reg <= 1'b0;
      seg_reg   <= SEG_DARK;
    end else begin
      digit_reg <= digit_next;
      valid_reg <= valid_next;
      seg_reg   <= seg_next;
    end
  end

  assign seg0  = seg_reg;
  assign valid = valid_reg;

  // SEG_LIT is only referenced when lamp test is compiled in.
  logic unused_lit;
  assign unused_lit = ^SEG_LIT;

endmodule

// File: tb/tb_hex_seven_seg.sv
// Directed testbench for hex_seven_seg.
// It drives one active-low instance and one active-high instance from the same inputs.
// The lamp test scenario is included when HEX_SEVEN_SEG_LAMP_TEST_EN is defined.
module tb_hex_seven_seg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a = 4'h0;
  logic       load = 1'b0;
  logic       blank = 1'b0;
`ifdef HEX_SEVEN_SEG_LAMP_TEST_EN
  logic       lamp_test = 1'b0;
`endif
  logic [6:0] seg0;
  logic       valid;
  logic [6:0] seg0_hi;
  logic       valid_hi;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] EXP_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 clk = ~clk;

  hex_seven_seg #(.ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .a(a), .load(load), .blank(blank),
`ifdef HEX_SEVEN_SEG_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .seg0(seg0), .valid(valid)
  );

  hex_seven_seg #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .a(a), .load(load), .blank(blank),
`ifdef HEX_SEVEN_SEG_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .seg0(seg0_hi), .valid(valid_hi)
  );

  // Advance one clock edge, then wait 1 time unit so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seg(input string name, input logic [6:0] exp_seg, input logic exp_valid);
    checks++;
    if (seg0 !== exp_seg || valid !== exp_valid) begin
      errors++;
      $display("FAIL %s: seg0=%h valid=%b, expected seg0=%h valid=%b", name, seg0, valid, exp_seg, exp_valid);
    end else begin
      $display("ok   %s: seg0=%h valid=%b", name, seg0, valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; blank = 1'b0; a = 4'h0;
    step(); check_seg("reset_cycle1", 7'h7F, 1'b0);
    step(); check_seg("reset_cycle2", 7'h7F, 1'b0);
    rst = 1'b0; a = 4'h5;
    step(); check_seg("post_reset_noload", 7'h7F, 1'b0);
    step(); check_seg("post_reset_hold", 7'h7F, 1'b0);
  endtask

  task automatic test_decode();
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); load = 1'b1;
      step();
      check_seg($sformatf("decode_%h", i), EXP_TAB[i], 1'b1);
    end
    load = 1'b0; a = 4'h0;
    step(); check_seg("decode_hold_F", 7'h0E, 1'b1);
  endtask

  task automatic test_same_value();
    a = 4'h3; load = 1'b1;
    step(); check_seg("same_first", 7'h30, 1'b1);
    step(); check_seg("same_reload", 7'h30, 1'b1);
    load = 1'b0;
    step(); check_seg("same_hold", 7'h30, 1'b1);
  endtask

  task automatic test_blank();
    a = 4'h8; load = 1'b1;
    step(); check_seg("blank_load8", 7'h00, 1'b1);
    load = 1'b0; blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_seg($sformatf("blank_dark%0d", i), 7'h7F, 1'b1);
    end
    blank = 1'b0;
    step(); check_seg("blank_restore", 7'h00, 1'b1);
  endtask

  task automatic test_load_blank();
    a = 4'h5; load = 1'b1; blank = 1'b1;
    step(); check_seg("loadblank_dark", 7'h7F, 1'b1);
    load = 1'b0; blank = 1'b0; a = 4'h0;
    step(); check_seg("loadblank_show5", 7'h12, 1'b1);
  endtask

  task automatic test_reset_midway();
    a = 4'h2; load = 1'b1; rst = 1'b1;
    step(); check_seg("midreset_override", 7'h7F, 1'b0);
    rst = 1'b0; load = 1'b0;
    step(); check_seg("midreset_dark", 7'h7F, 1'b0);
    a = 4'hA; load = 1'b1;
    step(); check_seg("midreset_loadA", 7'h08, 1'b1);
    load = 1'b0;
  endtask

  task automatic test_active_high();
    rst = 1'b1;
    step();
    checks++;
    if (seg0_hi !== 7'h00 || valid_hi !== 1'b0) begin
      errors++;
      $display("FAIL hi_reset: seg0=%h valid=%b, expected seg0=00 valid=0", seg0_hi, valid_hi);
    end else $display("ok   hi_reset: seg0=%h", seg0_hi);
    rst = 1'b0; a = 4'h1; load = 1'b1;
    step();
    checks++;
    if (seg0_hi !== 7'h06 || valid_hi !== 1'b1) begin
      errors++;
      $display("FAIL hi_load1: seg0=%h valid=%b, expected seg0=06 valid=1", seg0_hi, valid_hi);
    end else $display("ok   hi_load1: seg0=%h", seg0_hi);
    load = 1'b0; blank = 1'b1;
    step();
    checks++;
    if (seg0_hi !== 7'h00) begin
      errors++;
      $display("FAIL hi_blank: seg0=%h, expected 00", seg0_hi);
    end else $display("ok   hi_blank: seg0=%h", seg0_hi);
    blank = 1'b0; rst = 1'b1;
    step();
    checks++;
    if (seg0_hi !== 7'h00 || valid_hi !== 1'b0) begin
      errors++;
      $display("FAIL hi_reset2: seg0=%h valid=%b, expected seg0=00 valid=0", seg0_hi, valid_hi);
    end else $display("ok   hi_reset2: seg0=%h", seg0_hi);
    rst = 1'b0;
  endtask

`ifdef HEX_SEVEN_SEG_LAMP_TEST_EN
  task automatic test_lamp();
    a = 4'hC; load = 1'b1;
    step(); check_seg("lamp_loadC", 7'h46, 1'b1);
    load = 1'b0; lamp_test = 1'b1; blank = 1'b1;
    step(); check_seg("lamp_on", 7'h00, 1'b1);
    lamp_test = 1'b0; blank = 1'b0;
    step(); check_seg("lamp_off", 7'h46, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_same_value();
    test_blank();
    test_load_blank();
    test_reset_midway();
    test_active_high();
`ifdef HEX_SEVEN_SEG_LAMP_TEST_EN
    test_lamp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
